// File: rtl/data_memory_lsu_if.sv
// Request/response bus between a CPU datapath and data_memory_lsu.
// The CPU side uses the master modport, the memory the slave modport.
interface data_memory_lsu_if #(
  parameter int ADDR_W = 10
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_fault;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_fault
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_fault
  );
endinterface

// File: rtl/data_memory_lsu.sv
// Byte-addressed little-endian data memory with byte/half/word access,
// load extension, alignment faults and configurable access wait states.
module data_memory_lsu #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 1
) (
  input logic              clk,
  input logic              rst,
  data_memory_lsu_if.slave bus
);
  localparam int DEPTH = 32'd1 << (ADDR_W - 2);
  localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic             NO_WAIT  = (WAIT_CYCLES == 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  function automatic logic access_fault(input logic [1:0] size, input logic [1:0] lane);
    logic f;
    case (size)
      2'b00:   f = 1'b0;
      2'b01:   f = lane[0];
      2'b10:   f = (lane != 2'b00);
      default: f = 1'b1;
    endcase
    return f;
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] lane, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   r = {{24{b[7] & ~uns}}, b};
      2'b01:   r = {{16{h[15] & ~uns}}, h};
      2'b10:   r = word;
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] wdata,
                                              input logic [1:0] size, input logic [1:0] lane);
    logic [31:0] r;
    r = old;
    case (size)
      2'b00:   r[{lane, 3'b000} +: 8] = wdata[7:0];
      2'b01:   r[{lane[1], 4'b0000} +: 16] = wdata[15:0];
      2'b10:   r = wdata;
      default: r = old;
    endcase
    return r;
  endfunction

  state_t            state_r, state_next_s;
  logic [CNT_W-1:0]  cnt_r, cnt_next_s;
  logic              ready_r, resp_valid_r, resp_fault_r;
  logic [31:0]       resp_rdata_r;
  logic              we_r, uns_r;
  logic [1:0]        size_r;
  logic [ADDR_W-1:0] addr_r;
  logic [31:0]       wdata_r;
  logic [31:0]       mem_r [DEPTH];

  logic              accept_s, fault_s, access_s;
  logic              acc_we_s, acc_uns_s;
  logic [1:0]        acc_size_s;
  logic [ADDR_W-1:0] acc_addr_s;
  logic [31:0]       acc_wdata_s;
  logic [ADDR_W-3:0] acc_idx_s;
  logic [31:0]       acc_word_s;

  // ready_r is low during reset, so nothing is accepted until one edge after release
  assign accept_s = (state_r == S_IDLE) & ready_r & bus.req_valid;
  assign fault_s  = access_fault(bus.req_size, bus.req_addr[1:0]);
  assign access_s = (accept_s & ~fault_s & NO_WAIT) |
                    ((state_r == S_WAIT) & (cnt_r == CNT_ONE));

  // Access operands: live request on a zero-wait acceptance, captured copy otherwise
  always_comb begin
    if (state_r == S_IDLE) begin
      acc_we_s    = bus.req_we;
      acc_uns_s   = bus.req_unsigned;
      acc_size_s  = bus.req_size;
      acc_addr_s  = bus.req_addr;
      acc_wdata_s = bus.req_wdata;
    end else begin
      acc_we_s    = we_r;
      acc_uns_s   = uns_r;
      acc_size_s  = size_r;
      acc_addr_s  = addr_r;
      acc_wdata_s = wdata_r;
    end
  end

  assign acc_idx_s  = acc_addr_s[ADDR_W-1:2];
  assign acc_word_s = mem_r[acc_idx_s];

  // Next-state and wait-counter logic
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    case (state_r)
      S_IDLE: begin
        if (accept_s) begin
          if (fault_s || NO_WAIT) begin
            state_next_s = S_RESP;
          end else begin
            state_next_s = S_WAIT;
            cnt_next_s   = CNT_INIT;
          end
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_r == CNT_ONE) begin
          state_next_s = S_RESP;
          cnt_next_s   = '0;
        end else begin
          cnt_next_s = cnt_r - CNT_ONE;
        end
      end
      S_RESP: begin
        state_next_s = S_IDLE;
      end
      default: begin
        state_next_s = S_IDLE;
        cnt_next_s   = '0;
      end
    endcase
  end

  // State, counter and registered handshake outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= S_IDLE;
      cnt_r        <= '0;
      ready_r      <= 1'b0;
      resp_valid_r <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      cnt_r        <= cnt_next_s;
      ready_r      <= (state_next_s == S_IDLE);
      resp_valid_r <= (state_next_s == S_RESP);
    end
  end

  // Request capture at acceptance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_r    <= 1'b0;
      uns_r   <= 1'b0;
      size_r  <= 2'b00;
      addr_r  <= '0;
      wdata_r <= 32'h0000_0000;
    end else if (accept_s) begin
      we_r    <= bus.req_we;
      uns_r   <= bus.req_unsigned;
      size_r  <= bus.req_size;
      addr_r  <= bus.req_addr;
      wdata_r <= bus.req_wdata;
    end
  end

  // Response data/fault, held until the next response is produced
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_rdata_r <= 32'h0000_0000;
      resp_fault_r <= 1'b0;
    end else if (accept_s && fault_s) begin
      resp_rdata_r <= 32'h0000_0000;
      resp_fault_r <= 1'b1;
    end else if (access_s) begin
      resp_rdata_r <= acc_we_s ? 32'h0000_0000
                               : load_extract(acc_word_s, acc_size_s, acc_addr_s[1:0], acc_uns_s);
      resp_fault_r <= 1'b0;
    end
  end

  // Storage write on the access edge; contents survive reset
  always_ff @(posedge clk) begin
    if (access_s && acc_we_s) begin
      mem_r[acc_idx_s] <= store_merge(acc_word_s, acc_wdata_s, acc_size_s, acc_addr_s[1:0]);
    end
  end

  assign bus.req_ready  = ready_r;
  assign bus.resp_valid = resp_valid_r;
  assign bus.resp_rdata = resp_rdata_r;
  assign bus.resp_fault = resp_fault_r;
endmodule

// File: tb/tb_data_memory_lsu.sv
// Scoreboard bench for data_memory_lsu: three instances (0, 1 and 3 wait states)
// driven one at a time against a byte-array reference model.
module tb_data_memory_lsu;
  localparam int ADDR_W = 10;
  localparam int NI     = 3;

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  int          sel;
  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;
  int          last_acc = 0;
  logic        drv_valid, drv_we, drv_uns;
  logic [1:0]  drv_size;
  logic [ADDR_W-1:0] drv_addr;
  logic [31:0] drv_wdata;
  logic        ready_a  [NI];
  logic        rvalid_a [NI];
  logic        fault_a  [NI];
  logic [31:0] rdata_a  [NI];
  logic [7:0]  mem_m [NI][1024];
  exp_t        sb_q[$];
  exp_t        mon_e;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int wait_of(input int s);
    case (s)
      0:       return 0;
      1:       return 1;
      default: return 3;
    endcase
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int W = (g == 0) ? 0 : ((g == 1) ? 1 : 3);
    data_memory_lsu_if #(.ADDR_W(ADDR_W)) bus ();
    data_memory_lsu #(.ADDR_W(ADDR_W), .WAIT_CYCLES(W)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );
    assign bus.req_valid    = drv_valid && (sel == g);
    assign bus.req_we       = drv_we;
    assign bus.req_size     = drv_size;
    assign bus.req_unsigned = drv_uns;
    assign bus.req_addr     = drv_addr;
    assign bus.req_wdata    = drv_wdata;
    assign ready_a[g]       = bus.req_ready;
    assign rvalid_a[g]      = bus.resp_valid;
    assign fault_a[g]       = bus.resp_fault;
    assign rdata_a[g]       = bus.resp_rdata;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (instance %0d, cycle %0d)", name, act, exp, sel, cyc);
    end
  endtask

  // Reference model: byte-granular memory, spec alignment rules, arithmetic extension
  task automatic model_access(input int s, input logic we, input logic [1:0] size, input logic uns,
                              input int a, input logic [31:0] wd,
                              output logic [31:0] rd, output logic flt);
    int v;
    flt = (size == 2'd3) || (size == 2'd1 && (a % 2) != 0) || (size == 2'd2 && (a % 4) != 0);
    rd  = 32'd0;
    if (!flt) begin
      if (we) begin
        if (size == 2'd0) begin
          mem_m[s][a] = wd[7:0];
        end else if (size == 2'd1) begin
          mem_m[s][a]     = wd[7:0];
          mem_m[s][a + 1] = wd[15:8];
        end else begin
          for (int k = 0; k < 4; k++) mem_m[s][a + k] = wd[8*k +: 8];
        end
      end else if (size == 2'd0) begin
        v = int'(mem_m[s][a]);
        if (!uns && v >= 128) v = v - 256;
        rd = 32'(v);
      end else if (size == 2'd1) begin
        v = int'(mem_m[s][a]) + 256 * int'(mem_m[s][a + 1]);
        if (!uns && v >= 32768) v = v - 65536;
        rd = 32'(v);
      end else begin
        rd = {mem_m[s][a + 3], mem_m[s][a + 2], mem_m[s][a + 1], mem_m[s][a]};
      end
    end
  endtask

  // Present one request (called at a negedge); expectations are pushed at acceptance
  task automatic issue(input logic we, input logic [1:0] size, input logic uns, input int a,
                       input logic [31:0] wd, input bit lit, input logic [31:0] lit_rd,
                       input logic lit_flt, input bit chk_gap);
    exp_t        e;
    logic [31:0] mrd;
    logic        mflt;
    bit          done;
    drv_we    = we;
    drv_size  = size;
    drv_uns   = uns;
    drv_addr  = a[ADDR_W-1:0];
    drv_wdata = wd;
    drv_valid = 1'b1;
    done      = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      if (ready_a[sel]) begin
        done = 1'b1;
        model_access(sel, we, size, uns, a, wd, mrd, mflt);
        e.rdata = lit ? lit_rd : mrd;
        e.fault = lit ? lit_flt : mflt;
        e.due   = cyc + (e.fault ? 1 : wait_of(sel) + 1);
        sb_q.push_back(e);
        if (chk_gap) check("accept_spacing", 32'(cyc - last_acc), 32'(wait_of(sel) + 2));
        last_acc = cyc;
      end
      @(negedge clk);
    end
    drv_valid = 1'b0;
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: req_ready never high within 40 cycles (instance %0d)", sel);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && sb_q.size() != 0; i++) @(negedge clk);
    tests++;
    if (sb_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d responses outstanding, expected 0", sb_q.size());
    end
  endtask

  // Monitor: every response pops the scoreboard; a missing response times out
  initial begin
    forever begin
      @(negedge clk);
      if (rvalid_a[sel]) begin
        if (sb_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_resp: resp_valid=1 with no request outstanding (cycle %0d)", cyc);
        end else begin
          mon_e = sb_q.pop_front();
          check("resp_rdata", rdata_a[sel], mon_e.rdata);
          check("resp_fault", 32'(fault_a[sel]), 32'(mon_e.fault));
          check("resp_latency", 32'(cyc), 32'(mon_e.due));
        end
      end else if (sb_q.size() != 0 && cyc >= sb_q[0].due) begin
        tests++;
        fails++;
        $display("FAIL resp_timeout: no resp_valid at cycle %0d, expected by %0d", cyc, sb_q[0].due);
        void'(sb_q.pop_front());
      end
    end
  end

  initial begin
    bit          got;
    int          a;
    logic [1:0]  sz;
    for (int s = 0; s < NI; s++) for (int i = 0; i < 1024; i++) mem_m[s][i] = 8'h00;
    rst = 1'b1; sel = 0;
    drv_valid = 1'b0; drv_we = 1'b0; drv_size = 2'b00; drv_uns = 1'b0;
    drv_addr = '0; drv_wdata = 32'h0;
    repeat (3) @(negedge clk);
    for (int g = 0; g < NI; g++) begin
      check("rst_ready", 32'(ready_a[g]), 32'd0);
      check("rst_valid", 32'(rvalid_a[g]), 32'd0);
      check("rst_rdata", rdata_a[g], 32'd0);
      check("rst_fault", 32'(fault_a[g]), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 32'(ready_a[0]), 32'd1);

    // One wait state: word, byte, half, fault and top-word paths, back to back
    sel = 1;
    issue(1'b1, 2'd2, 1'b0, 'h020, 32'hDEADBEEF, 1'b1, 32'h0, 1'b0, 1'b0);
    issue(1'b0, 2'd2, 1'b0, 'h020, 32'h0,        1'b1, 32'hDEADBEEF, 1'b0, 1'b1);
    issue(1'b1, 2'd0, 1'b0, 'h021, 32'h00000080, 1'b1, 32'h0, 1'b0, 1'b1);
    issue(1'b0, 2'd2, 1'b0, 'h020, 32'h0,        1'b1, 32'hDEAD80EF, 1'b0, 1'b1);
    issue(1'b0, 2'd0, 1'b0, 'h021, 32'h0,        1'b1, 32'hFFFFFF80, 1'b0, 1'b1);
    issue(1'b0, 2'd0, 1'b1, 'h021, 32'h0,        1'b1, 32'h00000080, 1'b0, 1'b1);
    issue(1'b0, 2'd0, 1'b0, 'h023, 32'h0,        1'b1, 32'hFFFFFFDE, 1'b0, 1'b1);
    issue(1'b1, 2'd1, 1'b0, 'h022, 32'h00008001, 1'b1, 32'h0, 1'b0, 1'b1);
    issue(1'b0, 2'd2, 1'b0, 'h020, 32'h0,        1'b1, 32'h800180EF, 1'b0, 1'b1);
    issue(1'b0, 2'd1, 1'b0, 'h022, 32'h0,        1'b1, 32'hFFFF8001, 1'b0, 1'b1);
    issue(1'b0, 2'd1, 1'b1, 'h022, 32'h0,        1'b1, 32'h00008001, 1'b0, 1'b1);
    issue(1'b0, 2'd2, 1'b0, 'h021, 32'h0,        1'b1, 32'h0, 1'b1, 1'b1);
    issue(1'b1, 2'd1, 1'b0, 'h023, 32'h0000FFFF, 1'b1, 32'h0, 1'b1, 1'b0);
    issue(1'b0, 2'd3, 1'b0, 'h020, 32'h0,        1'b1, 32'h0, 1'b1, 1'b0);
    issue(1'b0, 2'd2, 1'b0, 'h020, 32'h0,        1'b1, 32'h800180EF, 1'b0, 1'b0);
    issue(1'b1, 2'd2, 1'b0, 'h3FC, 32'hA5A5A5A5, 1'b1, 32'h0, 1'b0, 1'b1);
    issue(1'b0, 2'd2, 1'b0, 'h3FC, 32'h0,        1'b1, 32'hA5A5A5A5, 1'b0, 1'b1);
    drain();

    // Zero wait states: latency 1, spacing 2
    sel = 0;
    issue(1'b1, 2'd2, 1'b0, 'h030, 32'h11223344, 1'b1, 32'h0, 1'b0, 1'b0);
    issue(1'b0, 2'd2, 1'b0, 'h030, 32'h0,        1'b1, 32'h11223344, 1'b0, 1'b1);
    issue(1'b0, 2'd0, 1'b0, 'h033, 32'h0,        1'b1, 32'h00000011, 1'b0, 1'b1);
    issue(1'b0, 2'd1, 1'b0, 'h032, 32'h0,        1'b1, 32'h00001122, 1'b0, 1'b1);
    issue(1'b0, 2'd1, 1'b0, 'h031, 32'h0,        1'b1, 32'h0, 1'b1, 1'b1);
    issue(1'b1, 2'd2, 1'b0, 'h3FC, 32'hA5A5A5A5, 1'b1, 32'h0, 1'b0, 1'b1);
    issue(1'b0, 2'd2, 1'b0, 'h3FC, 32'h0,        1'b1, 32'hA5A5A5A5, 1'b0, 1'b1);
    drain();

    // Three wait states: reset while a store is waiting drops it
    sel = 2;
    issue(1'b1, 2'd2, 1'b0, 'h040, 32'hCAFEF00D, 1'b1, 32'h0, 1'b0, 1'b0);
    issue(1'b0, 2'd2, 1'b0, 'h040, 32'h0,        1'b1, 32'hCAFEF00D, 1'b0, 1'b1);
    drain();
    drv_we = 1'b1; drv_size = 2'd2; drv_uns = 1'b0; drv_addr = 10'h010;
    drv_wdata = 32'h12345678; drv_valid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (ready_a[sel]) got = 1'b1;
      @(negedge clk);
    end
    drv_valid = 1'b0;
    check("midop_accepted", 32'(got), 32'd1);
    check("wait_ready_low", 32'(ready_a[sel]), 32'd0);
    rst = 1'b1;
    #1;
    check("midrst_valid", 32'(rvalid_a[sel]), 32'd0);
    check("midrst_rdata", rdata_a[sel], 32'd0);
    check("midrst_fault", 32'(fault_a[sel]), 32'd0);
    check("midrst_ready", 32'(ready_a[sel]), 32'd0);
    @(negedge clk);
    check("midrst_ready_hold", 32'(ready_a[sel]), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_midrst", 32'(ready_a[sel]), 32'd1);
    issue(1'b0, 2'd2, 1'b0, 'h010, 32'h0, 1'b1, 32'h00000000, 1'b0, 1'b0);
    issue(1'b0, 2'd2, 1'b0, 'h040, 32'h0, 1'b1, 32'hCAFEF00D, 1'b0, 1'b1);
    drain();

    // Randomized traffic on every instance, checked against the model
    for (int s = 0; s < NI; s++) begin
      sel = s;
      for (int n = 0; n < 40; n++) begin
        a  = int'($urandom_range(0, 63));
        if ($urandom_range(0, 7) == 0) a = 1020 + int'($urandom_range(0, 3));
        sz = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 1) == 0) begin
          if (sz == 2'd1) a = a & ~1;
          if (sz == 2'd2) a = a & ~3;
        end
        issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom(),
              1'b0, 32'h0, 1'b0, 1'b0);
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      drain();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
